// File: rtl/insn_mem_responder_pkg.sv
// insn_mem_pkg: shared FSM states, NOP constant and fetch address range check
package insn_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  function automatic logic addr_bad(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] bytes);
    return addr[1:0] != 2'd0 || addr < base || addr + 64'd4 > base + bytes;
  endfunction
endpackage

// File: rtl/insn_mem_responder_byte_ram.sv
// byte_ram: byte-write memory with asynchronous little-endian 32-bit word read
module byte_ram #(
  parameter int BYTES = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(BYTES)-1:0]   waddr,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(BYTES)-3:0]   widx,
  output logic [31:0]                rdata
);
  logic [7:0] mem [BYTES];
  // program-load byte write
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = {mem[{widx, 2'd3}], mem[{widx, 2'd2}], mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
endmodule

// File: rtl/insn_mem_responder.sv
// insn_mem_responder: fetch-side instruction memory with programmable latency and load port
module insn_mem_responder
  import insn_mem_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                AWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASEADDR    = 'h01000000,
  parameter int                MEM_BYTES   = 1024,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_insn_o,
  output logic [AWIDTH-1:0] rsp_addr_o,
  output logic              rsp_err_o,
  input  logic              ld_en_i,
  input  logic [AWIDTH-1:0] ld_addr_i,
  input  logic [7:0]        ld_data_i
);
  localparam int AB = $clog2(MEM_BYTES);
  state_t            state;
  logic [3:0]        cnt;
  logic [AWIDTH-1:0] cap_addr;
  logic [AB-3:0]     widx;
  logic [AB-1:0]     loff;
  logic              cap_err, ld_ok;
  logic [31:0]       word;
  logic [DWIDTH-1:0] cap_insn;
  // with zero wait states the capture edge is the accept edge, so read the live address
  assign cap_addr = state == IDLE ? req_addr_i : rsp_addr_o;
  assign widx     = (AB-2)'((cap_addr - BASEADDR) >> 2);
  assign loff     = AB'(ld_addr_i - BASEADDR);
  assign cap_err  = addr_bad(64'(cap_addr), 64'(BASEADDR), 64'(MEM_BYTES));
  assign ld_ok    = ld_en_i && !(ld_addr_i < BASEADDR) && 64'(ld_addr_i) < 64'(BASEADDR) + 64'(MEM_BYTES);
  assign cap_insn = cap_err ? DWIDTH'(NOP_INSN) : DWIDTH'(word);
  byte_ram #(.BYTES(MEM_BYTES)) ram (
    .clk   (clk),
    .we    (ld_ok),
    .waddr (loff),
    .wdata (ld_data_i),
    .widx  (widx),
    .rdata (word)
  );
  // request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_insn_o  <= '0;
      rsp_addr_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          rsp_addr_o  <= req_addr_i;
          cnt         <= 4'(WAIT_CYCLES);
          req_ready_o <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_insn_o  <= cap_insn;
            rsp_err_o   <= cap_err;
          end else state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_insn_o  <= cap_insn;
            rsp_err_o   <= cap_err;
          end
        end
        RESP: if (rsp_ready_i) begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_insn_mem_responder.sv
// tb_insn_mem_responder: directed checks of latency, backpressure, errors, load port and reset
module tb_insn_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        v1 = 1'b0, v3 = 1'b0, v0 = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        r1_ready, r1_valid, r1_err, r3_ready, r3_valid, r3_err, r0_ready, r0_valid, r0_err;
  logic [31:0] r1_insn, r1_addr, r3_insn, r3_addr, r0_insn, r0_addr;
  int tests = 0;
  int fails = 0;
  logic [31:0] ea [5] = '{32'h01000002, 32'h010003FC, 32'h01000400, 32'h00FFFFFC, 32'hFFFFFFFC};
  logic        ee [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] ei [5] = '{32'h00000013, 32'h00100093, 32'h00000013, 32'h00000013, 32'h00000013};
  logic [31:0] ba [4] = '{32'h01000000, 32'h01000004, 32'h01000008, 32'h0100000C};

  insn_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(r1_ready), .req_addr_i(req_addr),
    .rsp_valid_o(r1_valid), .rsp_ready_i(rsp_ready), .rsp_insn_o(r1_insn), .rsp_addr_o(r1_addr),
    .rsp_err_o(r1_err), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  insn_mem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid_i(v3), .req_ready_o(r3_ready), .req_addr_i(req_addr),
    .rsp_valid_o(r3_valid), .rsp_ready_i(rsp_ready), .rsp_insn_o(r3_insn), .rsp_addr_o(r3_addr),
    .rsp_err_o(r3_err), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  insn_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(r0_ready), .req_addr_i(req_addr),
    .rsp_valid_o(r0_valid), .rsp_ready_i(rsp_ready), .rsp_insn_o(r0_insn), .rsp_addr_o(r0_addr),
    .rsp_err_o(r0_err), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic req1(input logic [31:0] a, output int lat);
    v1 = 1'b1; req_addr = a;
    tick();
    v1 = 1'b0;
    lat = 1;
    while (!r1_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic ack1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++; if (r1_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", r1_ready); end
    tests++; if (r1_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", r1_valid); end
    tests++; if (r1_insn !== 32'h0) begin fails++; $display("FAIL reset_insn: got %h exp 0", r1_insn); end
    tests++; if (r1_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h exp 0", r1_addr); end
    tests++; if (r1_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", r1_err); end
    tests++; if ({r3_ready, r0_ready} !== 2'b11) begin fails++; $display("FAIL reset_ready_others: got %b exp 11", {r3_ready, r0_ready}); end
  endtask

  task automatic test_basic;
    int lat;
    load(32'h01000000, 8'h13); load(32'h01000001, 8'h05); load(32'h01000002, 8'h00); load(32'h01000003, 8'h00);
    req1(32'h01000000, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL basic_latency: got %0d exp 2", lat); end
    tests++; if (r1_insn !== 32'h00000513) begin fails++; $display("FAIL basic_insn: got %h exp 00000513", r1_insn); end
    tests++; if (r1_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b exp 0", r1_err); end
    tests++; if (r1_addr !== 32'h01000000) begin fails++; $display("FAIL basic_addr: got %h exp 01000000", r1_addr); end
    ack1();
    tests++; if ({r1_valid, r1_ready} !== 2'b01) begin fails++; $display("FAIL basic_handshake: got valid,ready=%b exp 01", {r1_valid, r1_ready}); end
  endtask

  task automatic test_backpressure;
    int lat;
    req1(32'h01000000, lat);
    for (int i = 0; i < 5; i++) begin
      req_addr = 32'h01000100 + 32'(i);
      tick();
      tests++;
      if (r1_valid !== 1'b1 || r1_insn !== 32'h00000513 || r1_addr !== 32'h01000000) begin
        fails++; $display("FAIL hold_%0d: got valid=%b insn=%h addr=%h exp 1 00000513 01000000", i, r1_valid, r1_insn, r1_addr);
      end
    end
    ack1();
    tests++; if ({r1_valid, r1_ready} !== 2'b01) begin fails++; $display("FAIL hold_release: got valid,ready=%b exp 01", {r1_valid, r1_ready}); end
  endtask

  task automatic test_errors;
    int lat;
    load(32'h010003FC, 8'h93); load(32'h010003FD, 8'h00); load(32'h010003FE, 8'h10); load(32'h010003FF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      req1(ea[i], lat);
      tests++;
      if (lat !== 2 || r1_err !== ee[i] || r1_insn !== ei[i] || r1_addr !== ea[i]) begin
        fails++; $display("FAIL err_%h: got lat=%0d err=%b insn=%h addr=%h exp 2 %b %h %h", ea[i], lat, r1_err, r1_insn, r1_addr, ee[i], ei[i], ea[i]);
      end
      ack1();
    end
  endtask

  task automatic test_load_collision;
    int lat;
    v1 = 1'b1; req_addr = 32'h01000000;
    tick();
    v1 = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h01000000; ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    tests++; if (r1_valid !== 1'b1 || r1_insn !== 32'h00000513) begin fails++; $display("FAIL collide_old: got valid=%b insn=%h exp 1 00000513", r1_valid, r1_insn); end
    load(32'h01000001, 8'h77);
    tests++; if (r1_insn !== 32'h00000513) begin fails++; $display("FAIL collide_held: got %h exp 00000513", r1_insn); end
    ack1();
    load(32'h01000400, 8'h55);
    load(32'h00FFFFFF, 8'h66);
    req1(32'h01000000, lat);
    tests++; if (r1_insn !== 32'h000077AA) begin fails++; $display("FAIL collide_new: got %h exp 000077AA", r1_insn); end
    ack1();
    req1(32'h010003FC, lat);
    tests++; if (r1_insn !== 32'h00100093) begin fails++; $display("FAIL load_below_base: got %h exp 00100093", r1_insn); end
    ack1();
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    bit seen;
    v3 = 1'b1; req_addr = 32'h01000000;
    tick();
    v3 = 1'b0;
    lat = 1;
    while (!r3_valid && lat < 20) begin tick(); lat++; end
    tests++; if (lat !== 4 || r3_insn !== 32'h000077AA) begin fails++; $display("FAIL wait3: got lat=%0d insn=%h exp 4 000077AA", lat, r3_insn); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    tests++; if (r3_ready !== 1'b0) begin fails++; $display("FAIL midwait_busy: got %b exp 0", r3_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (r3_valid) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midwait_norsp: got %b exp 0", seen); end
    tests++; if (r3_ready !== 1'b1) begin fails++; $display("FAIL midwait_ready: got %b exp 1", r3_ready); end
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = ba[i];
      tick();
      req_addr = 32'hDEADBEEC;
      tests++;
      if (r0_valid !== 1'b1 || r0_addr !== ba[i] || r0_err !== 1'b0) begin
        fails++; $display("FAIL b2b_rsp_%0d: got valid=%b addr=%h err=%b exp 1 %h 0", i, r0_valid, r0_addr, r0_err, ba[i]);
      end
      tick();
      tests++;
      if ({r0_valid, r0_ready} !== 2'b01) begin
        fails++; $display("FAIL b2b_gap_%0d: got valid,ready=%b exp 01", i, {r0_valid, r0_ready});
      end
    end
    v0 = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_load_collision();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
